sram_arbiter: RTL

Four-port SRAM arbiter in the clk_sram (100 MHz) domain, placed between the GPU requesters and the single SRAM controller backend. Port 0 is the display scanout prefetcher and has strict priority. Ports 1–3 (rasterizer writes, texture reads, SPI host access) share the remaining bandwidth round-robin. The block forwards single-word and read-burst transactions, routes burst beats and acks back to the granted port, and flags backend protocol violations.

---
 rtl/sram_arbiter_if.sv | 50 +++++
 rtl/sram_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// Requester and backend signal bundle for the four-port SRAM arbiter.
// Port i of every flattened per-port vector occupies slice i.
interface sram_arbiter_if;
  logic [3:0]   port_req;
  logic [3:0]   port_we;
  logic [95:0]  port_addr;
  logic [127:0] port_wdata;
  logic [31:0]  port_burst_len;
  logic [3:0]   port_ready;
  logic [3:0]   port_ack;
  logic [31:0]  port_rdata;
  logic [15:0]  port_burst_rdata;
  logic [3:0]   port_burst_data_valid;
  logic         mem_req;
  logic         mem_we;
  logic [23:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [7:0]   mem_burst_len;
  logic [31:0]  mem_rdata;
  logic [15:0]  mem_burst_rdata;
  logic         mem_burst_data_valid;
  logic         mem_ack;
  logic         mem_ready;

  // Arbiter side.
  modport slave (
    input  port_req, port_we, port_addr,
    input  port_wdata, port_burst_len,
    output port_ready, port_ack, port_rdata,
    output port_burst_rdata, port_burst_data_valid,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_burst_len,
    input  mem_rdata, mem_burst_rdata,
    input  mem_burst_data_valid, mem_ack,
    input  mem_ready
  );

  // Requester/backend environment side.
  modport master (
    output port_req, port_we, port_addr,
    output port_wdata, port_burst_len,
    input  port_ready, port_ack, port_rdata,
    input  port_burst_rdata, port_burst_data_valid,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_burst_len,
    output mem_rdata, mem_burst_rdata,
    output mem_burst_data_valid, mem_ack,
    output mem_ready
  );
endinterface

// File: rtl/sram_arbiter.sv
// Four-port SRAM arbiter: port 0 strict priority, ports 1-3 round-robin.
// Forwards single-word and read-burst transactions, flags backend misuse.
module sram_arbiter (
  input  logic          clk_sram,
  input  logic          rst_n_sram,
  sram_arbiter_if.slave bus,
  output logic          err_protocol
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  rr_q, rr_d;
  logic [8:0]  beat_q, beat_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  blen_q, blen_d;
  logic        err_q, err_d;

  logic [1:0]  win;
  logic [1:0]  c0, c1, c2;
  logic        win_we;
  logic [9:0]  beat_sum;
  logic [3:0]  gnt_oh;
  logic        active;

  // Winner: port 0 first, else first requester after rr_q in 1->2->3.
  always_comb begin
    c0 = (rr_q == 2'd3) ? 2'd1 : rr_q + 2'd1;
    c1 = (c0 == 2'd3) ? 2'd1 : c0 + 2'd1;
    c2 = (c1 == 2'd3) ? 2'd1 : c1 + 2'd1;
    if (bus.port_req[0])       win = 2'd0;
    else if (bus.port_req[c0]) win = c0;
    else if (bus.port_req[c1]) win = c1;
    else                       win = c2;
  end

  assign win_we   = bus.port_we[win];
  assign beat_sum = {1'b0, beat_q}
                  + {9'd0, bus.mem_burst_data_valid};

  // Next-state: grant in IDLE, beat count and completion in ACTIVE.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    blen_d  = blen_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_ack || bus.mem_burst_data_valid)
          err_d = 1'b1;
        if (|bus.port_req && bus.mem_ready) begin
          state_d = ACTIVE;
          grant_d = win;
          beat_d  = 9'd0;
          req_d   = 1'b1;
          we_d    = win_we;
          addr_d  = bus.port_addr[int'(win)*24 +: 24];
          wdata_d = bus.port_wdata[int'(win)*32 +: 32];
          blen_d  = win_we ? 8'd0
                  : bus.port_burst_len[int'(win)*8 +: 8];
        end
      end
      ACTIVE: begin
        if (bus.mem_burst_data_valid && beat_q != 9'h1FF)
          beat_d = beat_q + 9'd1;
        if (bus.mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          blen_d  = 8'd0;
          if (grant_q != 2'd0)
            rr_d = grant_q;
          if (blen_q != 8'd0 && beat_sum != {2'b00, blen_q})
            err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and backend-facing registers; reset abandons any transaction.
  always_ff @(posedge clk_sram or negedge rst_n_sram) begin
    if (!rst_n_sram) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      rr_q    <= 2'd3;
      beat_q  <= 9'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 24'd0;
      wdata_q <= 32'd0;
      blen_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      blen_q  <= blen_d;
      err_q   <= err_d;
    end
  end

  assign active = (state_q == ACTIVE);
  assign gnt_oh = 4'b0001 << grant_q;

  assign bus.port_ready = {4{bus.mem_ready && !active}};
  assign bus.port_ack   = (active && bus.mem_ack) ? gnt_oh : 4'd0;
  assign bus.port_burst_data_valid =
    (active && bus.mem_burst_data_valid) ? gnt_oh : 4'd0;
  assign bus.port_rdata       = bus.mem_rdata;
  assign bus.port_burst_rdata = bus.mem_burst_rdata;

  assign bus.mem_req       = req_q;
  assign bus.mem_we        = we_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_burst_len = blen_q;
  assign err_protocol      = err_q;

endmodule
